// File: rtl/hilo_acc_reg_pkg.sv
// Shared constants for the HI/LO accumulate register pair: opcode encoding,
// reset level, FSM state encoding and small opcode-decode helpers.
package hilo_acc_reg_pkg;

  localparam int unsigned HILO_OP_W = 3;

  // Reset is asserted when rst equals this level.
  localparam logic RST_ACTIVE = 1'b0;

  typedef enum logic [HILO_OP_W-1:0] {
    HILO_NOP   = 3'd0,
    HILO_WHI   = 3'd1,
    HILO_WLO   = 3'd2,
    HILO_WPAIR = 3'd3,
    HILO_MADD  = 3'd4,
    HILO_MSUB  = 3'd5
  } hilo_op_e;

  // ST_ACC means the stage-1 accumulate register is occupied.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } hilo_state_e;

  // Opcode writes the HI half directly.
  function automatic logic op_writes_hi(input logic [HILO_OP_W-1:0] op);
    return (op == HILO_WHI) || (op == HILO_WPAIR);
  endfunction

  // Opcode writes the LO half directly.
  function automatic logic op_writes_lo(input logic [HILO_OP_W-1:0] op);
    return (op == HILO_WLO) || (op == HILO_WPAIR);
  endfunction

  // Opcode is a two-stage multiply-accumulate/subtract.
  function automatic logic op_is_acc(input logic [HILO_OP_W-1:0] op);
    return (op == HILO_MADD) || (op == HILO_MSUB);
  endfunction

endpackage

// File: rtl/hilo_acc_reg_if.sv
// Operation/readback bundle for hilo_acc_reg.
//   master: issues op_valid_i/op_i/hi_i/lo_i, observes ready, state and
//           forwarded read outputs.
//   slave : the register block itself.
interface hilo_acc_reg_if #(
  parameter int unsigned DATA_W = 32
);
  import hilo_acc_reg_pkg::*;

  logic                 op_valid_i;
  logic                 op_ready_o;
  logic [HILO_OP_W-1:0] op_i;
  logic [DATA_W-1:0]    hi_i;
  logic [DATA_W-1:0]    lo_i;
  logic [DATA_W-1:0]    hi_o;
  logic [DATA_W-1:0]    lo_o;
  logic [DATA_W-1:0]    rd_hi_o;
  logic [DATA_W-1:0]    rd_lo_o;
  logic                 rd_valid_o;
  logic                 busy_o;

  modport master (
    output op_valid_i, op_i, hi_i, lo_i,
    input  op_ready_o, hi_o, lo_o, rd_hi_o, rd_lo_o, rd_valid_o, busy_o
  );

  modport slave (
    input  op_valid_i, op_i, hi_i, lo_i,
    output op_ready_o, hi_o, lo_o, rd_hi_o, rd_lo_o, rd_valid_o, busy_o
  );

endinterface

// File: rtl/hilo_acc_addsub.sv
// Combinational W-bit add/subtract; carry and borrow are discarded so the
// result wraps modulo 2^W.
//   i_a, i_b : operands
//   i_sub    : 1 = i_a - i_b, 0 = i_a + i_b
//   o_res_c  : result (combinational)
module hilo_acc_addsub #(
  parameter int unsigned W = 64
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_sub,
  output logic [W-1:0] o_res_c
);

  always_comb begin
    o_res_c = i_sub ? (i_a - i_b) : (i_a + i_b);
  end

endmodule

// File: rtl/hilo_acc_reg.sv
// HI/LO register pair with HI-only, LO-only and pair writes, a two-stage
// multiply-accumulate/subtract over {HI,LO}, and a forwarded read port.
//   clk : rising-edge clock
//   rst : synchronous reset, active low
//   bus : hilo_acc_reg_if slave (op handshake, write data, HI/LO outputs,
//         forwarded read data, rd_valid_o, busy_o)
module hilo_acc_reg
  import hilo_acc_reg_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter bit          ACC_EN = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  hilo_acc_reg_if.slave  bus
);

  localparam int unsigned ACC_W = 2 * DATA_W;

  hilo_state_e       r_state;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;
  logic [ACC_W-1:0]  r_prod;
  logic              r_sub;

  hilo_state_e       w_state_nxt;
  logic [DATA_W-1:0] w_hi_nxt;
  logic [DATA_W-1:0] w_lo_nxt;
  logic [ACC_W-1:0]  w_prod_nxt;
  logic              w_sub_nxt;
  logic              w_accept;
  logic              w_fwd_hi;
  logic              w_fwd_lo;
  logic [ACC_W-1:0]  w_acc_res;

  // Accumulate datapath: current pair +/- the captured product.
  hilo_acc_addsub #(
    .W (ACC_W)
  ) u_addsub (
    .i_a     ({r_hi, r_lo}),
    .i_b     (r_prod),
    .i_sub   (r_sub),
    .o_res_c (w_acc_res)
  );

  // State and datapath registers; reset drops any accumulate in flight.
  always_ff @(posedge clk) begin
    if (rst == RST_ACTIVE) begin
      r_state <= ST_IDLE;
      r_hi    <= '0;
      r_lo    <= '0;
      r_prod  <= '0;
      r_sub   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      r_prod  <= w_prod_nxt;
      r_sub   <= w_sub_nxt;
    end
  end

  // Next-state, write decode and forwarding selects.
  always_comb begin
    w_state_nxt = r_state;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    w_prod_nxt  = r_prod;
    w_sub_nxt   = r_sub;
    w_accept    = 1'b0;
    w_fwd_hi    = 1'b0;
    w_fwd_lo    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_accept = bus.op_valid_i;
        if (w_accept) begin
          if (op_writes_hi(bus.op_i)) begin
            w_hi_nxt = bus.hi_i;
            w_fwd_hi = 1'b1;
          end
          if (op_writes_lo(bus.op_i)) begin
            w_lo_nxt = bus.lo_i;
            w_fwd_lo = 1'b1;
          end
          // With ACC_EN clear, MADD/MSUB fall through as an accepted NOP.
          if (ACC_EN && op_is_acc(bus.op_i)) begin
            w_prod_nxt  = {bus.hi_i, bus.lo_i};
            w_sub_nxt   = (bus.op_i == HILO_MSUB);
            w_state_nxt = ST_ACC;
          end
        end
      end

      ST_ACC: begin
        // Nothing is accepted here, so the pair cannot change under us.
        {w_hi_nxt, w_lo_nxt} = w_acc_res;
        w_state_nxt          = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Ready depends only on state, never on op_valid_i.
  assign bus.op_ready_o = (r_state == ST_IDLE);
  assign bus.busy_o     = (r_state == ST_ACC);
  assign bus.rd_valid_o = (r_state == ST_IDLE);
  assign bus.hi_o       = r_hi;
  assign bus.lo_o       = r_lo;

  // Written halves bypass the register in the accepting cycle.
  assign bus.rd_hi_o = w_fwd_hi ? bus.hi_i : r_hi;
  assign bus.rd_lo_o = w_fwd_lo ? bus.lo_i : r_lo;

  // Accept is only observed through the forwarding selects.
  logic w_unused;
  assign w_unused = w_accept;

endmodule

// File: tb/tb_hilo_acc_reg.sv
// Scoreboard bench for hilo_acc_reg (ACC_EN=1 main instance, ACC_EN=0 side
// instance).
module tb_hilo_acc_reg;
  import hilo_acc_reg_pkg::*;

  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hilo_acc_reg_if #(.DATA_W(DW)) b1 ();
  hilo_acc_reg_if #(.DATA_W(DW)) b0 ();

  hilo_acc_reg #(.DATA_W(DW), .ACC_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b1.slave)
  );

  hilo_acc_reg #(.DATA_W(DW), .ACC_EN(1'b0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (b0.slave)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_acc_seen = 0;

  logic [63:0] m_pair;
  logic [63:0] m_prod;
  logic        m_s1;
  logic        m_sub;
  logic [63:0] sb_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Retire the oldest scoreboard entry against the DUT pair.
  task automatic pop_cmp(input string tag);
    logic [63:0] e;
    if (sb_q.size() == 0) begin
      check_eq({tag, "_sb_underflow"}, 64'(sb_q.size()), 64'd1);
    end else begin
      e = sb_q.pop_front();
      check_eq(tag, {b1.hi_o, b1.lo_o}, e);
    end
  endtask

  // One clock on the main instance: drive, check comb outputs, clock, retire.
  task automatic step(input logic v, input logic [2:0] op, input logic [31:0] hi,
                      input logic [31:0] lo, input logic r);
    logic        acc;
    logic        fwd;
    logic [63:0] exp_rd;
    logic [63:0] nxt;
    rst           = r;
    b1.op_valid_i = v;
    b1.op_i       = op;
    b1.hi_i       = hi;
    b1.lo_i       = lo;
    #3;
    fwd = v && !m_s1;
    acc = fwd && r;
    check_eq("ready", 64'(b1.op_ready_o), 64'(!m_s1));
    check_eq("rd_valid", 64'(b1.rd_valid_o), 64'(!m_s1));
    exp_rd = m_pair;
    if (fwd && (op == 3'd1 || op == 3'd3)) exp_rd[63:32] = hi;
    if (fwd && (op == 3'd2 || op == 3'd3)) exp_rd[31:0]  = lo;
    check_eq("rd_fwd", {b1.rd_hi_o, b1.rd_lo_o}, exp_rd);
    if (b1.op_valid_i && b1.op_ready_o && r) n_acc_seen++;
    nxt = m_pair;
    if (acc) begin
      case (op)
        3'd1, 3'd2, 3'd3: nxt = exp_rd;
        3'd4:             nxt = m_pair + {hi, lo};
        3'd5:             nxt = m_pair - {hi, lo};
        default:          nxt = m_pair;
      endcase
      sb_q.push_back(nxt);
    end
    @(posedge clk);
    #1;
    if (!r) begin
      m_pair = '0;
      m_s1   = 1'b0;
      sb_q.delete();
    end else if (m_s1) begin
      m_s1   = 1'b0;
      m_pair = m_sub ? (m_pair - m_prod) : (m_pair + m_prod);
      pop_cmp("acc_commit");
    end else if (acc) begin
      if (op == 3'd4 || op == 3'd5) begin
        m_s1   = 1'b1;
        m_prod = {hi, lo};
        m_sub  = (op == 3'd5);
      end else begin
        m_pair = nxt;
        pop_cmp("write");
      end
    end
    check_eq("pair", {b1.hi_o, b1.lo_o}, m_pair);
    check_eq("busy", 64'(b1.busy_o), 64'(m_s1));
  endtask

  initial begin
    m_pair = '0;
    m_prod = '0;
    m_s1   = 1'b0;
    m_sub  = 1'b0;
    b0.op_valid_i = 1'b0;
    b0.op_i       = 3'd0;
    b0.hi_i       = '0;
    b0.lo_i       = '0;

    // Reset held two cycles with a WPAIR 5/7 presented.
    rst           = 1'b0;
    b1.op_valid_i = 1'b1;
    b1.op_i       = 3'd3;
    b1.hi_i       = 32'd5;
    b1.lo_i       = 32'd7;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_pair", {b1.hi_o, b1.lo_o}, 64'd0);
    check_eq("rst_ready", 64'(b1.op_ready_o), 64'd1);
    check_eq("rst_busy", 64'(b1.busy_o), 64'd0);
    check_eq("rst_rdvalid", 64'(b1.rd_valid_o), 64'd1);
    check_eq("rst_pair0", {b0.hi_o, b0.lo_o}, 64'd0);
    step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
    check_eq("post_rst_pair", {b1.hi_o, b1.lo_o}, 64'd0);

    // Partial writes with forwarding.
    step(1'b1, 3'd3, 32'hAAAA0000, 32'h0000BBBB, 1'b1);
    step(1'b1, 3'd1, 32'h12345678, 32'hDEADBEEF, 1'b1);
    check_eq("whi_pair", {b1.hi_o, b1.lo_o}, {32'h12345678, 32'h0000BBBB});
    step(1'b1, 3'd2, 32'hFFFFFFFF, 32'h00C0FFEE, 1'b1);
    check_eq("wlo_pair", {b1.hi_o, b1.lo_o}, {32'h12345678, 32'h00C0FFEE});

    // MADD with carry out of LO.
    step(1'b1, 3'd3, 32'h0, 32'hFFFFFFFF, 1'b1);
    step(1'b1, 3'd4, 32'h0, 32'h1, 1'b1);
    check_eq("madd_busy", 64'(b1.busy_o), 64'd1);
    check_eq("madd_ready", 64'(b1.op_ready_o), 64'd0);
    check_eq("madd_rdvalid", 64'(b1.rd_valid_o), 64'd0);
    step(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
    check_eq("madd_carry", {b1.hi_o, b1.lo_o}, 64'h00000001_00000000);
    check_eq("madd_idle", 64'(b1.busy_o), 64'd0);

    // Back-to-back MADD held four cycles, then a fifth.
    step(1'b1, 3'd3, 32'h0, 32'h0, 1'b1);
    n_acc_seen = 0;
    repeat (4) step(1'b1, 3'd4, 32'h0, 32'h3, 1'b1);
    check_eq("b2b_lo", {b1.hi_o, b1.lo_o}, 64'd6);
    check_eq("b2b_accepts", 64'(n_acc_seen), 64'd2);
    step(1'b1, 3'd4, 32'h0, 32'h3, 1'b1);
    check_eq("b2b_third", 64'(n_acc_seen), 64'd3);
    step(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
    check_eq("b2b_final", {b1.hi_o, b1.lo_o}, 64'd9);

    // MSUB wrap below zero.
    step(1'b1, 3'd3, 32'h0, 32'h0, 1'b1);
    step(1'b1, 3'd5, 32'h0, 32'h1, 1'b1);
    step(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
    check_eq("msub_wrap", {b1.hi_o, b1.lo_o}, 64'hFFFFFFFF_FFFFFFFF);

    // ACC_EN=0 instance: MSUB is an accepted NOP.
    b0.op_valid_i = 1'b1;
    b0.op_i       = 3'd3;
    b0.hi_i       = 32'h0;
    b0.lo_i       = 32'h0;
    @(posedge clk);
    #1;
    b0.op_i = 3'd5;
    b0.lo_i = 32'h1;
    #3;
    check_eq("noacc_ready_pre", 64'(b0.op_ready_o), 64'd1);
    @(posedge clk);
    #1;
    b0.op_valid_i = 1'b0;
    check_eq("noacc_ready", 64'(b0.op_ready_o), 64'd1);
    check_eq("noacc_busy", 64'(b0.busy_o), 64'd0);
    check_eq("noacc_pair", {b0.hi_o, b0.lo_o}, 64'd0);
    @(posedge clk);
    #1;
    check_eq("noacc_pair2", {b0.hi_o, b0.lo_o}, 64'd0);

    // Reset during an in-flight accumulate.
    step(1'b1, 3'd3, 32'h0, 32'd10, 1'b1);
    step(1'b1, 3'd4, 32'h0, 32'd5, 1'b1);
    step(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
    check_eq("rstacc_pair", {b1.hi_o, b1.lo_o}, 64'd0);
    check_eq("rstacc_busy", 64'(b1.busy_o), 64'd0);
    step(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
    step(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
    check_eq("rstacc_nowrite", {b1.hi_o, b1.lo_o}, 64'd0);

    // Random mix, including reserved opcodes and stalls.
    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
           32'($urandom), 32'($urandom), 1'b1);
    end
    step(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
    check_eq("sb_drain", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
